hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
//  Parametrised forwarding and hazard controller for the 5-stage RV32 pipeline.
//  - Per-source EX-stage bypass select for NSRC operands, from MEM and WB.
//  - Load-use stall FSM, with LOAD_STALL configurable for multi-cycle data memory.
//  - Saturating stall-cycle counter.
//  - Optional register scoreboard for the long-latency mul/div unit.
//  Sits between the ID/EX/MEM/WB pipeline registers and the PC/IF-ID enable and EX-mux logic.
// PARAMETERS
//  REG_AW      5   register address width (2**REG_AW architectural registers)
//  NSRC        2   number of source operands per instruction (2 or 3)
//  LOAD_STALL  1   bubbles inserted on a load-use hazard (1..7)
//  CNT_W       32  stall counter width
// PORTS
//  CLK            in   1              clock, rising edge
//  RSTn           in   1              reset, synchronous, active-low
//  RS_EX          in   NSRC*REG_AW    EX-stage source addresses, src i at [i*REG_AW +: REG_AW]
//  RS_ID          in   NSRC*REG_AW    ID-stage source addresses
//  USE_ID         in   NSRC           ID source i is actually read
//  RD_EX          in   REG_AW         EX destination
//  memRead_EX     in   1              EX instruction is a load
//  RD_MEM         in   REG_AW         MEM destination
//  RD_WB          in   REG_AW         WB destination
//  regWrite_MEM   in   1              MEM instruction writes the register file
//  regWrite_WB    in   1              WB instruction writes the register file
//  flush          in   1              taken branch/jump resolved in EX; kills IF/ID
//  long_issue     in   1              ID issues a mul/div (qualified internally by ~stall)
//  RD_ID          in   REG_AW         ID destination (for scoreboard)
//  long_done      in   1              mul/div writes its result this cycle
//  RD_LONG        in   REG_AW         mul/div destination being written
//  fwd_sel        out  NSRC*2         per-source select: 10 = MEM, 01 = WB, 00 = regfile
//  stall          out  1              hold PC and IF/ID
//  bubble         out  1              insert NOP into ID/EX; always equals stall
//  stall_cnt      out  CNT_W          total stall cycles, saturating
// BEHAVIOUR
//  - Reset: while RSTn = 0 all outputs read 0.
//    - Next-state reset values: state = IDLE, cnt = 0, stall_cnt = 0, all busy bits = 0.
//  - Forwarding (combinational, zero latency), per source i:
//    - MEM hit: regWrite_MEM & RD_MEM != 0 & RD_MEM == RS_EX[i] -> 10.
//    - Otherwise WB hit (same rule using WB fields) -> 01.
//    - Otherwise -> 00.
//    - MEM has priority when both stages hit. x0 is never forwarded.
//  - Load-use detect:
//    lu = memRead_EX & RD_EX != 0 & OR_i(USE_ID[i] & RS_ID[i] == RD_EX).
//  - FSM states IDLE and LU_STALL; internal cnt is 3 bits.
//    - IDLE:
//      - lu -> stall = 1.
//      - If LOAD_STALL > 1: next state LU_STALL, cnt = LOAD_STALL-1.
//      - If LOAD_STALL == 1: remain in IDLE.
//    - LU_STALL: stall = 1 and cnt decrements; return to IDLE when cnt == 1.
//    - Total stall on a load-use hazard is exactly LOAD_STALL cycles; the consumer
//      then receives the load result via WB/MEM forwarding.
//  - Flush overrides everything:
//    - stall = 0 in the flush cycle.
//    - Next state IDLE, cnt = 0.
//    - No scoreboard set in that cycle.
//  - stall_cnt increments on each cycle with stall = 1 and holds at all-ones (no wrap).
//  - Simultaneous lu and scoreboard hazard: stall = 1, counted once.
// CONFIGURATION
//  - Macro HAZARD_LONG_SB_EN.
//  - Defined: scoreboard busy[2**REG_AW] is instantiated.
//    - Set busy[RD_ID] on long_issue & ~stall & ~flush & RD_ID != 0.
//    - Clear busy[RD_LONG] on long_done.
//    - Set and clear of the same register in the same cycle: set wins.
//    - sb_hz = OR_i(USE_ID[i] & busy[RS_ID[i]] & ~(long_done & RD_LONG == RS_ID[i]))
//      | (busy[RD_ID] & RD_ID != 0 & ~(long_done & RD_LONG == RD_ID)), i.e. RAW or WAW.
//    - sb_hz asserts stall combinationally and does not affect the FSM state.
//  - Undefined: no busy storage; sb_hz = 0; long_issue, RD_ID, long_done and RD_LONG
//    are ignored.
// STRUCTURE
//  - Package hazard_pkg holds:
//    - fwd_sel_t constants FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10.
//    - FSM state encoding: IDLE = 1'b0, LU_STALL = 1'b1.
//  - Sub-module fwd_src_sel: one source comparator and priority encoder,
//    instantiated NSRC times in a generate loop.
//  - Top level holds the FSM, the stall counter and the scoreboard.
// TESTING
//  - Dual hit: RS_EX = {5, 5}, RD_MEM = 5, RD_WB = 5, both regWrite = 1
//    -> fwd_sel = {10, 10}; RD_MEM = 0 instead -> {01, 01}.
//  - x0: RD_MEM = 0, RS_EX[0] = 0, regWrite_MEM = 1 -> fwd_sel[1:0] = 00.
//  - Load-use, LOAD_STALL = 2: memRead_EX = 1, RD_EX = 7, RS_ID[1] = 7, USE_ID = 2'b10
//    -> stall high exactly 2 cycles, stall_cnt += 2; USE_ID = 0 -> no stall.
//  - Flush in the second LU_STALL cycle -> stall = 0 that cycle, next cycle IDLE,
//    stall_cnt += 1 only.
//  - HAZARD_LONG_SB_EN: issue mul to x9, then a reader of x9 -> stall until long_done with
//    RD_LONG = 9; stall drops in the long_done cycle; a write to x9 in ID also stalls (WAW).
//  - Reset mid-LU_STALL: RSTn = 0 for 1 cycle -> outputs 0, state IDLE, stall_cnt = 0,
//    busy cleared.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// rtl/hazard_forward_ctrl_pkg.sv - shared types for the forwarding/hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// rtl/hazard_forward_ctrl_if.sv - pipeline-side bundle between the stage registers and the hazard controller
interface hazard_forward_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 32
);
  logic [NSRC*REG_AW-1:0] RS_EX;
  logic [NSRC*REG_AW-1:0] RS_ID;
  logic [NSRC-1:0]        USE_ID;
  logic [REG_AW-1:0]      RD_EX;
  logic                   memRead_EX;
  logic [REG_AW-1:0]      RD_MEM;
  logic [REG_AW-1:0]      RD_WB;
  logic                   regWrite_MEM;
  logic                   regWrite_WB;
  logic                   flush;
  logic                   long_issue;
  logic [REG_AW-1:0]      RD_ID;
  logic                   long_done;
  logic [REG_AW-1:0]      RD_LONG;
  logic [NSRC*2-1:0]      fwd_sel;
  logic                   stall;
  logic                   bubble;
  logic [CNT_W-1:0]       stall_cnt;

  modport master (
    output RS_EX, RS_ID, USE_ID, RD_EX, memRead_EX, RD_MEM, RD_WB,
           regWrite_MEM, regWrite_WB, flush, long_issue, RD_ID, long_done, RD_LONG,
    input  fwd_sel, stall, bubble, stall_cnt
  );

  modport slave (
    input  RS_EX, RS_ID, USE_ID, RD_EX, memRead_EX, RD_MEM, RD_WB,
           regWrite_MEM, regWrite_WB, flush, long_issue, RD_ID, long_done, RD_LONG,
    output fwd_sel, stall, bubble, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_src_sel.sv
// rtl/hazard_forward_ctrl_fwd_src_sel.sv - bypass select for one EX source operand
module fwd_src_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rd_mem,
  input  logic [REG_AW-1:0] rd_wb,
  input  logic              reg_write_mem,
  input  logic              reg_write_wb,
  output fwd_sel_t          sel
);

  // MEM holds the younger result, so it wins over WB; x0 is hard-wired zero.
  always_comb begin
    sel = FWD_RF;
    if (reg_write_mem && (rd_mem != '0) && (rd_mem == rs))
      sel = FWD_MEM;
    else if (reg_write_wb && (rd_wb != '0) && (rd_wb == rs))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - EX bypass select, load-use stall FSM, stall counter; HAZARD_LONG_SB_EN adds the mul/div scoreboard
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NSRC       = 2,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 32
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  hazard_forward_ctrl_if.slave bus
);

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              lu;
  logic              sb_hz;
  logic              stall_int;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [NSRC*2-1:0] fwd_raw;

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    fwd_sel_t sel_i;
    fwd_src_sel #(.REG_AW(REG_AW)) u_sel (
      .rs            (bus.RS_EX[i*REG_AW +: REG_AW]),
      .rd_mem        (bus.RD_MEM),
      .rd_wb         (bus.RD_WB),
      .reg_write_mem (bus.regWrite_MEM),
      .reg_write_wb  (bus.regWrite_WB),
      .sel           (sel_i)
    );
    assign fwd_raw[i*2 +: 2] = sel_i;
  end

  always_comb begin
    lu = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (bus.USE_ID[i] && (bus.RS_ID[i*REG_AW +: REG_AW] == bus.RD_EX))
        lu = 1'b1;
    lu = lu & bus.memRead_EX & (bus.RD_EX != '0);
  end

`ifdef HAZARD_LONG_SB_EN
  localparam int NREG = 2**REG_AW;
  logic [NREG-1:0] busy;
  logic            sb_set;

  // A register being written back this cycle no longer blocks its reader.
  always_comb begin
    sb_hz = 1'b0;
    for (int i = 0; i < NSRC; i++)
      if (bus.USE_ID[i] && busy[bus.RS_ID[i*REG_AW +: REG_AW]] &&
          !(bus.long_done && (bus.RD_LONG == bus.RS_ID[i*REG_AW +: REG_AW])))
        sb_hz = 1'b1;
    if (busy[bus.RD_ID] && (bus.RD_ID != '0) &&
        !(bus.long_done && (bus.RD_LONG == bus.RD_ID)))
      sb_hz = 1'b1;
  end

  assign sb_set = bus.long_issue & ~stall_int & ~bus.flush & (bus.RD_ID != '0);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      busy <= '0;
    end else begin
      if (bus.long_done) busy[bus.RD_LONG] <= 1'b0;
      if (sb_set)        busy[bus.RD_ID]   <= 1'b1;
    end
  end
`else
  logic unused_sb;
  assign unused_sb = ^{bus.long_issue, bus.RD_ID, bus.long_done, bus.RD_LONG};
  assign sb_hz     = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (bus.flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (lu && (LOAD_STALL > 1)) begin
            state_nxt = LU_STALL;
            cnt_nxt   = 3'(LOAD_STALL - 1);
          end
        end
        LU_STALL: begin
          cnt_nxt = cnt - 3'd1;
          if (cnt == 3'd1) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    stall_int = 1'b0;
    if (RSTn && !bus.flush)
      stall_int = (state == LU_STALL) | lu | sb_hz;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn)
      stall_cnt_q <= '0;
    else if (stall_int && !(&stall_cnt_q))
      stall_cnt_q <= stall_cnt_q + 1'b1;
  end

  assign bus.stall     = stall_int;
  assign bus.bubble    = stall_int;
  assign bus.stall_cnt = RSTn ? stall_cnt_q : '0;
  assign bus.fwd_sel   = RSTn ? fwd_raw : '0;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed self-checking bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;
  logic clk = 1'b0;
  logic rstn;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_cnt;

  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.REG_AW(5), .NSRC(2), .CNT_W(32)) b1 ();
  hazard_forward_ctrl_if #(.REG_AW(5), .NSRC(2), .CNT_W(2))  b2 ();

  hazard_forward_ctrl #(.REG_AW(5), .NSRC(2), .LOAD_STALL(2), .CNT_W(32)) dut (
    .CLK(clk), .RSTn(rstn), .bus(b1.slave));
  hazard_forward_ctrl #(.REG_AW(5), .NSRC(2), .LOAD_STALL(1), .CNT_W(2)) dut_sat (
    .CLK(clk), .RSTn(rstn), .bus(b2.slave));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    b1.RS_EX = '0; b1.RS_ID = '0; b1.USE_ID = '0; b1.RD_EX = '0; b1.memRead_EX = 1'b0;
    b1.RD_MEM = '0; b1.RD_WB = '0; b1.regWrite_MEM = 1'b0; b1.regWrite_WB = 1'b0;
    b1.flush = 1'b0; b1.long_issue = 1'b0; b1.RD_ID = '0; b1.long_done = 1'b0; b1.RD_LONG = '0;
    b2.RS_EX = '0; b2.RS_ID = '0; b2.USE_ID = '0; b2.RD_EX = '0; b2.memRead_EX = 1'b0;
    b2.RD_MEM = '0; b2.RD_WB = '0; b2.regWrite_MEM = 1'b0; b2.regWrite_WB = 1'b0;
    b2.flush = 1'b0; b2.long_issue = 1'b0; b2.RD_ID = '0; b2.long_done = 1'b0; b2.RD_LONG = '0;
  endtask

  task automatic lu_on;
    b1.memRead_EX = 1'b1; b1.RD_EX = 5'd7; b1.RS_ID = {5'd7, 5'd0}; b1.USE_ID = 2'b10;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    idle_inputs();
    b1.RS_EX = {5'd5, 5'd5}; b1.RD_MEM = 5'd5; b1.regWrite_MEM = 1'b1;
    lu_on();
    tick(); #2;
    checks++; if (b1.fwd_sel !== 4'b0000) begin errors++; $display("FAIL rst_fwd act=%b exp=0000", b1.fwd_sel); end
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL rst_stall act=%b exp=0", b1.stall); end
    checks++; if (b1.bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble act=%b exp=0", b1.bubble); end
    checks++; if (b1.stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_cnt act=%0d exp=0", b1.stall_cnt); end
    tick();
    rstn = 1'b1;
    idle_inputs();
    exp_cnt = 32'd0;
    #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL rel_stall act=%b exp=0", b1.stall); end
    checks++; if (b1.stall_cnt !== exp_cnt) begin errors++; $display("FAIL rel_cnt act=%0d exp=%0d", b1.stall_cnt, exp_cnt); end
  endtask

  task automatic test_forward;
    idle_inputs();
    b1.RS_EX = {5'd5, 5'd5}; b1.RD_MEM = 5'd5; b1.RD_WB = 5'd5;
    b1.regWrite_MEM = 1'b1; b1.regWrite_WB = 1'b1; #2;
    checks++; if (b1.fwd_sel !== 4'b1010) begin errors++; $display("FAIL fwd_dual act=%b exp=1010", b1.fwd_sel); end
    b1.RD_MEM = 5'd0; #2;
    checks++; if (b1.fwd_sel !== 4'b0101) begin errors++; $display("FAIL fwd_wb act=%b exp=0101", b1.fwd_sel); end
    b1.RS_EX = {5'd5, 5'd0}; b1.RD_MEM = 5'd0; b1.RD_WB = 5'd0; #2;
    checks++; if (b1.fwd_sel[1:0] !== 2'b00) begin errors++; $display("FAIL fwd_x0 act=%b exp=00", b1.fwd_sel[1:0]); end
    b1.RS_EX = {5'd3, 5'd4}; b1.RD_MEM = 5'd4; b1.RD_WB = 5'd3; #2;
    checks++; if (b1.fwd_sel !== 4'b0110) begin errors++; $display("FAIL fwd_mix act=%b exp=0110", b1.fwd_sel); end
    b1.RD_WB = 5'd4; b1.regWrite_MEM = 1'b0; #2;
    checks++; if (b1.fwd_sel !== 4'b0001) begin errors++; $display("FAIL fwd_nowr act=%b exp=0001", b1.fwd_sel); end
    idle_inputs();
    tick();
  endtask

  task automatic test_load_use;
    idle_inputs(); lu_on(); #2;
    checks++; if (b1.stall !== 1'b1 || b1.bubble !== 1'b1) begin errors++; $display("FAIL lu_c1 act=%b%b exp=11", b1.stall, b1.bubble); end
    tick(); #2;
    checks++; if (b1.stall !== 1'b1) begin errors++; $display("FAIL lu_c2 act=%b exp=1", b1.stall); end
    tick();
    b1.memRead_EX = 1'b0; exp_cnt += 2; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL lu_c3 act=%b exp=0", b1.stall); end
    checks++; if (b1.stall_cnt !== exp_cnt) begin errors++; $display("FAIL lu_cnt act=%0d exp=%0d", b1.stall_cnt, exp_cnt); end
    lu_on(); b1.USE_ID = 2'b00; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL lu_nouse act=%b exp=0", b1.stall); end
    b1.USE_ID = 2'b01; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL lu_other act=%b exp=0", b1.stall); end
    lu_on(); b1.RD_EX = 5'd0; b1.RS_ID = '0; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL lu_x0 act=%b exp=0", b1.stall); end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush;
    lu_on(); #2;
    checks++; if (b1.stall !== 1'b1) begin errors++; $display("FAIL fl_c1 act=%b exp=1", b1.stall); end
    tick();
    b1.flush = 1'b1; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL fl_c2 act=%b exp=0", b1.stall); end
    tick();
    idle_inputs(); exp_cnt += 1; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL fl_idle act=%b exp=0", b1.stall); end
    checks++; if (b1.stall_cnt !== exp_cnt) begin errors++; $display("FAIL fl_cnt act=%0d exp=%0d", b1.stall_cnt, exp_cnt); end
    lu_on(); b1.flush = 1'b1; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL fl_lu act=%b exp=0", b1.stall); end
    tick();
    idle_inputs(); #2;
    checks++; if (b1.stall !== 1'b0 || b1.stall_cnt !== exp_cnt) begin errors++; $display("FAIL fl_after act=%b/%0d exp=0/%0d", b1.stall, b1.stall_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid;
    idle_inputs(); b1.long_issue = 1'b1; b1.RD_ID = 5'd9; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL rm_issue act=%b exp=0", b1.stall); end
    tick();
    idle_inputs(); lu_on(); #2;
    checks++; if (b1.stall !== 1'b1) begin errors++; $display("FAIL rm_lu act=%b exp=1", b1.stall); end
    tick();
    rstn = 1'b0; b1.RS_EX = {5'd7, 5'd7}; b1.RD_MEM = 5'd7; b1.regWrite_MEM = 1'b1; #2;
    checks++; if (b1.stall !== 1'b0 || b1.bubble !== 1'b0) begin errors++; $display("FAIL rm_stall act=%b%b exp=00", b1.stall, b1.bubble); end
    checks++; if (b1.fwd_sel !== 4'b0000 || b1.stall_cnt !== 32'd0) begin errors++; $display("FAIL rm_out act=%b/%0d exp=0000/0", b1.fwd_sel, b1.stall_cnt); end
    tick();
    rstn = 1'b1; idle_inputs(); b1.RS_ID = {5'd0, 5'd9}; b1.USE_ID = 2'b01; exp_cnt = 32'd0; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL rm_after act=%b exp=0", b1.stall); end
    checks++; if (b1.stall_cnt !== exp_cnt) begin errors++; $display("FAIL rm_cnt act=%0d exp=%0d", b1.stall_cnt, exp_cnt); end
    idle_inputs();
    tick();
  endtask

  task automatic test_scoreboard;
    idle_inputs(); b1.long_issue = 1'b1; b1.RD_ID = 5'd9; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL sb_issue act=%b exp=0", b1.stall); end
    tick();
    idle_inputs(); b1.RD_ID = 5'd3; b1.RS_ID = {5'd0, 5'd9}; b1.USE_ID = 2'b01;
`ifdef HAZARD_LONG_SB_EN
    for (int k = 0; k < 3; k++) begin
      #2;
      checks++; if (b1.stall !== 1'b1) begin errors++; $display("FAIL sb_raw%0d act=%b exp=1", k, b1.stall); end
      tick();
    end
    exp_cnt += 3;
    b1.long_done = 1'b1; b1.RD_LONG = 5'd9; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL sb_done act=%b exp=0", b1.stall); end
    tick();
    b1.long_done = 1'b0; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL sb_clr act=%b exp=0", b1.stall); end
    idle_inputs(); b1.long_issue = 1'b1; b1.RD_ID = 5'd9; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL sb_issue2 act=%b exp=0", b1.stall); end
    tick();
    idle_inputs(); b1.RD_ID = 5'd9; #2;
    checks++; if (b1.stall !== 1'b1) begin errors++; $display("FAIL sb_waw act=%b exp=1", b1.stall); end
    tick();
    exp_cnt += 1;
    b1.long_done = 1'b1; b1.RD_LONG = 5'd9; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL sb_waw_done act=%b exp=0", b1.stall); end
    tick();
    idle_inputs(); b1.long_issue = 1'b1; b1.RD_ID = 5'd9; b1.long_done = 1'b1; b1.RD_LONG = 5'd9; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL sb_setclr act=%b exp=0", b1.stall); end
    tick();
    idle_inputs(); b1.RS_ID = {5'd9, 5'd0}; b1.USE_ID = 2'b10; #2;
    checks++; if (b1.stall !== 1'b1) begin errors++; $display("FAIL sb_setwins act=%b exp=1", b1.stall); end
    tick();
    exp_cnt += 1;
    b1.long_done = 1'b1; b1.RD_LONG = 5'd9; tick();
`else
    #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL sb_off_raw act=%b exp=0", b1.stall); end
    b1.RD_ID = 5'd9; b1.USE_ID = 2'b00; #2;
    checks++; if (b1.stall !== 1'b0) begin errors++; $display("FAIL sb_off_waw act=%b exp=0", b1.stall); end
    tick();
`endif
    idle_inputs(); #2;
    checks++; if (b1.stall_cnt !== exp_cnt) begin errors++; $display("FAIL sb_cnt act=%0d exp=%0d", b1.stall_cnt, exp_cnt); end
    tick();
  endtask

  task automatic test_saturate;
    logic [1:0] exp_sat;
    idle_inputs();
    b2.memRead_EX = 1'b1; b2.RD_EX = 5'd4; b2.RS_ID = {5'd0, 5'd4}; b2.USE_ID = 2'b01;
    for (int k = 0; k < 5; k++) begin
      exp_sat = (k < 3) ? 2'(k) : 2'd3;
      #2;
      checks++; if (b2.stall !== 1'b1) begin errors++; $display("FAIL sat_stall%0d act=%b exp=1", k, b2.stall); end
      checks++; if (b2.stall_cnt !== exp_sat) begin errors++; $display("FAIL sat_cnt%0d act=%0d exp=%0d", k, b2.stall_cnt, exp_sat); end
      tick();
    end
    idle_inputs(); #2;
    checks++; if (b2.stall !== 1'b0 || b2.stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_end act=%b/%0d exp=0/3", b2.stall, b2.stall_cnt); end
  endtask

  initial begin
    rstn = 1'b0;
    exp_cnt = 32'd0;
    idle_inputs();
    tick();
    test_reset();
    test_forward();
    test_load_use();
    test_flush();
    test_reset_mid();
    test_scoreboard();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
